// File: rtl/data_array_pkg.sv
// data_array_pkg: shared types, default geometry and round-robin helper for the banked data array.
package data_array_pkg;
    localparam int DEF_NUM_WAYS            = 4;
    localparam int DEF_NUM_BANKS           = 4;
    localparam int DEF_SETS_PER_BANK_WIDTH = 8;
    localparam int DEF_BLOCK_WIDTH         = 512;
    localparam int DEF_NUM_RD_PORTS        = 2;
    localparam int DEF_CNT_WIDTH           = 16;
    localparam int DEF_BANK_SEL_WIDTH      = $clog2(DEF_NUM_BANKS);

    typedef logic [DEF_BANK_SEL_WIDTH-1:0]      bank_idx_t;
    typedef logic [DEF_SETS_PER_BANK_WIDTH-1:0] set_idx_t;
    typedef logic [DEF_BLOCK_WIDTH-1:0]         block_t;
    typedef logic [DEF_BLOCK_WIDTH/8-1:0]       byte_en_t;

    typedef struct packed {
        logic      valid;
        set_idx_t  set;
        bank_idx_t bank;
    } rd_req_t;

    function automatic int port_rr_next(input int winner, input int num_ports);
        return (winner + 1) % num_ports;
    endfunction
endpackage

// File: rtl/bank_rr_arbiter.sv
// bank_rr_arbiter: per-bank round-robin over read ports; ports hitting the winner's set are
// merged into the grant, others targeting the bank are denied.
module bank_rr_arbiter
    import data_array_pkg::*;
#(
    parameter int P  = 2,
    parameter int SW = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [P-1:0]         target,
    input  logic [P-1:0][SW-1:0] set_sel,
    output logic [P-1:0]         grant,
    output logic                 denied,
    output logic [SW-1:0]        rd_set
);
    localparam int PW = P > 1 ? $clog2(P) : 1;
    logic [PW-1:0] rr_q;
    logic [PW-1:0] win;
    logic          found;
    int            idx;
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < P; i++) begin
            idx = (int'(rr_q) + i) % P;
            if (!found && target[PW'(idx)]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
        rd_set = set_sel[win];
        for (int i = 0; i < P; i++)
            grant[i] = target[i] && set_sel[i] == set_sel[win];
        denied = |(target & ~grant);
    end
    // Pointer only moves when the bank actually turned someone away.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) rr_q <= '0;
        else if (denied) rr_q <= PW'(port_rr_next(int'(win), P));
endmodule

// File: rtl/banked_data_array_mp.sv
// banked_data_array_mp: NUM_WAYS x NUM_BANKS sync-read SRAMs, NUM_RD_PORTS arbitrated read ports, one
// byte-masked write port. Define DATA_ARRAY_WR_BYPASS_EN to forward same-cycle writes to colliding reads.
module banked_data_array_mp
    import data_array_pkg::*;
#(
    parameter int NUM_WAYS            = DEF_NUM_WAYS,
    parameter int NUM_BANKS           = DEF_NUM_BANKS,
    parameter int SETS_PER_BANK_WIDTH = DEF_SETS_PER_BANK_WIDTH,
    parameter int BLOCK_WIDTH         = DEF_BLOCK_WIDTH,
    parameter int NUM_RD_PORTS        = DEF_NUM_RD_PORTS,
    parameter int CNT_WIDTH           = DEF_CNT_WIDTH,
    localparam int BSW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1,
    localparam int SW  = SETS_PER_BANK_WIDTH,
    localparam int BW  = BLOCK_WIDTH,
    localparam int P   = NUM_RD_PORTS,
    localparam int NBY = BLOCK_WIDTH / 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [P-1:0]                          rd_req_valid_i,
    output logic [P-1:0]                          rd_req_ready_o,
    input  logic [P-1:0][SW-1:0]                  rd_bank_addr_i,
    input  logic [P-1:0][BSW-1:0]                 rd_bank_sel_i,
    output logic [P-1:0]                          rd_rsp_valid_o,
    output logic [P-1:0][NUM_WAYS-1:0][BW-1:0]    rd_rdata_o,
    input  logic                                  w_valid_i,
    input  logic [SW-1:0]                         w_bank_addr_i,
    input  logic [BSW-1:0]                        w_bank_sel_i,
    input  logic [NUM_WAYS-1:0]                   we_way_mask_i,
    input  logic [NBY-1:0]                        w_byte_en_i,
    input  logic [BW-1:0]                         wdata_i,
    output logic [CNT_WIDTH-1:0]                  conflict_cnt_o
);
    logic [NUM_BANKS-1:0][P-1:0]            bank_grant;
    logic [NUM_BANKS-1:0]                   bank_denied;
    logic [NUM_BANKS-1:0][SW-1:0]           bank_rd_set;
    logic [NUM_WAYS-1:0][NUM_BANKS-1:0][BW-1:0] sram_q;
    logic [P-1:0]                           rsp_valid_q;
    logic [P-1:0][BSW-1:0]                  bank_sel_q;
    logic [CNT_WIDTH-1:0]                   cnt_q;

    genvar b, w;
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [P-1:0] tgt;
        logic         rd_en;
        // Gating with rst_ni keeps ready low and arbitration idle while in reset.
        always_comb
            for (int p = 0; p < P; p++)
                tgt[p] = rst_ni && rd_req_valid_i[p] && rd_bank_sel_i[p] == BSW'(b);
        bank_rr_arbiter #(.P(P), .SW(SW)) u_arb (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .target  (tgt),
            .set_sel (rd_bank_addr_i),
            .grant   (bank_grant[b]),
            .denied  (bank_denied[b]),
            .rd_set  (bank_rd_set[b])
        );
        assign rd_en = |bank_grant[b];
        for (w = 0; w < NUM_WAYS; w++) begin : g_way
            logic [BW-1:0] mem [2**SW];
            logic [BW-1:0] rd_q;
            always_ff @(posedge clk_i) begin
                if (w_valid_i && we_way_mask_i[w] && w_bank_sel_i == BSW'(b))
                    for (int i = 0; i < NBY; i++)
                        if (w_byte_en_i[i]) mem[w_bank_addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                if (rd_en) rd_q <= mem[bank_rd_set[b]];
            end
            assign sram_q[w][b] = rd_q;
        end
    end

    always_comb begin
        rd_req_ready_o = '0;
        for (int i = 0; i < NUM_BANKS; i++) rd_req_ready_o |= bank_grant[i];
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            bank_sel_q  <= '0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= rd_req_ready_o;
            bank_sel_q  <= rd_bank_sel_i;
            cnt_q       <= (|bank_denied && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        end

    assign rd_rsp_valid_o = rsp_valid_q;
    assign conflict_cnt_o = cnt_q;

`ifdef DATA_ARRAY_WR_BYPASS_EN
    logic [P-1:0][NUM_WAYS-1:0] byp_hit_q;
    logic [BW-1:0]              byp_data_q;
    logic [BW-1:0]              byp_mask_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) byp_hit_q <= '0;
        else
            for (int p = 0; p < P; p++)
                for (int i = 0; i < NUM_WAYS; i++)
                    byp_hit_q[p][i] <= rd_req_ready_o[p] && w_valid_i && we_way_mask_i[i] &&
                                       w_bank_sel_i == rd_bank_sel_i[p] && w_bank_addr_i == rd_bank_addr_i[p];
    always_ff @(posedge clk_i) begin
        byp_data_q <= wdata_i;
        for (int i = 0; i < NBY; i++) byp_mask_q[8*i +: 8] <= {8{w_byte_en_i[i]}};
    end
    always_comb
        for (int p = 0; p < P; p++)
            for (int i = 0; i < NUM_WAYS; i++)
                rd_rdata_o[p][i] = !rsp_valid_q[p] ? '0 :
                                   byp_hit_q[p][i] ? (sram_q[i][bank_sel_q[p]] & ~byp_mask_q) | (byp_data_q & byp_mask_q) :
                                   sram_q[i][bank_sel_q[p]];
`else
    always_comb
        for (int p = 0; p < P; p++)
            for (int i = 0; i < NUM_WAYS; i++)
                rd_rdata_o[p][i] = rsp_valid_q[p] ? sram_q[i][bank_sel_q[p]] : '0;
`endif
endmodule

// File: tb/tb_banked_data_array_mp.sv
// tb_banked_data_array_mp: directed vectors for arbitration, merge, byte enables, bypass and reset.
module tb_banked_data_array_mp;
    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic [1:0]                rd_req_valid_i;
    logic [1:0]                rd_req_ready_o;
    logic [1:0][7:0]           rd_bank_addr_i;
    logic [1:0][1:0]           rd_bank_sel_i;
    logic [1:0]                rd_rsp_valid_o;
    logic [1:0][3:0][511:0]    rd_rdata_o;
    logic                      w_valid_i;
    logic [7:0]                w_bank_addr_i;
    logic [1:0]                w_bank_sel_i;
    logic [3:0]                we_way_mask_i;
    logic [63:0]               w_byte_en_i;
    logic [511:0]              wdata_i;
    logic [15:0]               conflict_cnt_o;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    banked_data_array_mp dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rd_req_valid_i (rd_req_valid_i),
        .rd_req_ready_o (rd_req_ready_o),
        .rd_bank_addr_i (rd_bank_addr_i),
        .rd_bank_sel_i  (rd_bank_sel_i),
        .rd_rsp_valid_o (rd_rsp_valid_o),
        .rd_rdata_o     (rd_rdata_o),
        .w_valid_i      (w_valid_i),
        .w_bank_addr_i  (w_bank_addr_i),
        .w_bank_sel_i   (w_bank_sel_i),
        .we_way_mask_i  (we_way_mask_i),
        .w_byte_en_i    (w_byte_en_i),
        .wdata_i        (wdata_i),
        .conflict_cnt_o (conflict_cnt_o)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        rd_req_valid_i = '0;
        w_valid_i      = 1'b0;
    endtask

    task automatic wr(input logic [1:0] bank, input logic [7:0] set, input logic [3:0] ways,
                      input logic [511:0] data, input logic [63:0] be);
        w_valid_i     = 1'b1;
        w_bank_sel_i  = bank;
        w_bank_addr_i = set;
        we_way_mask_i = ways;
        wdata_i       = data;
        w_byte_en_i   = be;
    endtask

    task automatic rd(input int p, input logic [1:0] bank, input logic [7:0] set);
        rd_req_valid_i[p] = 1'b1;
        rd_bank_sel_i[p]  = bank;
        rd_bank_addr_i[p] = set;
    endtask

    initial begin
        idle();
        rd_bank_sel_i = '0; rd_bank_addr_i = '0;
        w_bank_sel_i = '0; w_bank_addr_i = '0; we_way_mask_i = '0; w_byte_en_i = '0; wdata_i = '0;
        rd(0, 2'd0, 8'h00);
        #2;
        check("rst_ready", rd_req_ready_o, 2'b00);
        check("rst_rsp_valid", rd_rsp_valid_o, 2'b00);
        check("rst_cnt", conflict_cnt_o, 16'd0);
        tick(); tick();
        idle();
        rst_ni = 1'b1;
        tick();

        // way 1 write then read
        wr(2'd2, 8'h05, 4'b0010, {64{8'hA5}}, {64{1'b1}});
        tick();
        idle();
        rd(0, 2'd2, 8'h05);
        #1 check("wr_rd_ready", rd_req_ready_o, 2'b01);
        tick();
        idle();
        check("wr_rd_rsp_valid", rd_rsp_valid_o, 2'b01);
        check("wr_rd_data", rd_rdata_o[0][1], {64{8'hA5}});
        check("wr_rd_idle_port_zero", rd_rdata_o[1][1], 512'd0);

        // bank conflict, different sets
        rd(0, 2'd1, 8'h03);
        rd(1, 2'd1, 8'h07);
        #1 check("conf_ready_c0", rd_req_ready_o, 2'b01);
        tick();
        rd_req_valid_i[0] = 1'b0;
        #1 check("conf_ready_c1", rd_req_ready_o, 2'b10);
        check("conf_cnt_c1", conflict_cnt_o, 16'd1);
        check("conf_rsp_c1", rd_rsp_valid_o, 2'b01);
        tick();
        idle();
        check("conf_cnt_c2", conflict_cnt_o, 16'd1);
        check("conf_rsp_c2", rd_rsp_valid_o, 2'b10);

        // same bank, same set merge
        wr(2'd3, 8'h09, 4'b1111, {64{8'h3C}}, {64{1'b1}});
        tick();
        idle();
        rd(0, 2'd3, 8'h09);
        rd(1, 2'd3, 8'h09);
        #1 check("merge_ready", rd_req_ready_o, 2'b11);
        tick();
        idle();
        check("merge_rsp", rd_rsp_valid_o, 2'b11);
        check("merge_data_p0", rd_rdata_o[0][2], {64{8'h3C}});
        check("merge_data_p1", rd_rdata_o[1][2], {64{8'h3C}});
        check("merge_cnt", conflict_cnt_o, 16'd1);

        // byte enables
        wr(2'd0, 8'h10, 4'b1111, {64{8'hFF}}, {64{1'b1}});
        tick();
        wr(2'd0, 8'h10, 4'b1111, 512'd0, 64'h000F);
        tick();
        idle();
        rd(0, 2'd0, 8'h10);
        rd(1, 2'd2, 8'h05);
        #1 check("distinct_ready", rd_req_ready_o, 2'b11);
        tick();
        idle();
        check("byte_en_data", rd_rdata_o[0][3], {{60{8'hFF}}, 32'h0});
        check("distinct_data_p1", rd_rdata_o[1][1], {64{8'hA5}});
        check("distinct_cnt", conflict_cnt_o, 16'd1);

        // same-cycle write/read collision
        wr(2'd0, 8'h20, 4'b0001, {64{8'h22}}, {64{1'b1}});
        tick();
        wr(2'd0, 8'h20, 4'b0001, {64{8'h11}}, {64{1'b1}});
        rd(0, 2'd0, 8'h20);
        tick();
        idle();
`ifdef DATA_ARRAY_WR_BYPASS_EN
        check("collide_data", rd_rdata_o[0][0], {64{8'h11}});
`else
        check("collide_data", rd_rdata_o[0][0], {64{8'h22}});
`endif
        rd(0, 2'd0, 8'h20);
        tick();
        idle();
        check("collide_after", rd_rdata_o[0][0], {64{8'h11}});

        // reset with a response pending
        rd(0, 2'd2, 8'h05);
        tick();
        idle();
        check("pre_rst_rsp", rd_rsp_valid_o, 2'b01);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_rsp", rd_rsp_valid_o, 2'b00);
        check("mid_rst_rdata", 512'(|rd_rdata_o), 512'd0);
        check("mid_rst_cnt", conflict_cnt_o, 16'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        rd(0, 2'd1, 8'h01);
        rd(1, 2'd1, 8'h02);
        #1 check("post_rst_grant", rd_req_ready_o, 2'b01);
        tick();
        idle();
        check("post_rst_cnt", conflict_cnt_o, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
